// File: rtl/fp32_pkg.sv
// Shared binary32 constants, FSM state type and operand classification
// for the floating-point arithmetic blocks.
package fp32_pkg;

    localparam int FP32_BIAS    = 127;
    localparam int FP32_EXP_MAX = 255;

    localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
    localparam logic [30:0] FP32_INF_MAG = 31'h7F800000;

    // Quotient bits produced by the restoring iteration (2 above the
    // 24-bit significand: one normalisation bit plus guard).
    localparam int DIV_ITERS = 26;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Subnormals are flushed: any zero exponent field counts as zero.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.zero = (x[30:23] == 8'h00);
        c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        return c;
    endfunction

endpackage

// File: rtl/mant_div_iter.sv
// Restoring mantissa divider: q = floor(ma * 2^25 / mb), one quotient bit
// per cycle. done is high during the cycle in which the last bit is formed.
module mant_div_iter
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] ma,
    input  logic [23:0] mb,
    output logic        busy,
    output logic        done,
    output logic [25:0] q,
    output logic        rem_nz
);

    logic [25:0] rem;
    logic [23:0] divisor_r;
    logic [4:0]  cnt;
    logic        ge;
    logic [25:0] rem_sub;

    assign busy   = (cnt != 5'd0);
    assign done   = (cnt == 5'd1);
    assign rem_nz = (rem != 26'd0);

    // Trial subtraction; the remainder stays below 2*mb, so 26 bits suffice.
    always_comb begin
        ge      = (rem >= {2'b00, divisor_r});
        rem_sub = ge ? (rem - {2'b00, divisor_r}) : rem;
    end

    // Iteration state: load on start, shift in one quotient bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            divisor_r <= '0;
            cnt       <= '0;
            q         <= '0;
        end else if (start) begin
            rem       <= {2'b00, ma};
            divisor_r <= mb;
            cnt       <= 5'(DIV_ITERS);
            q         <= '0;
        end else if (busy) begin
            q   <= {q[24:0], ge};
            cnt <= cnt - 5'd1;
            // Final remainder is kept unshifted so rem_nz is the true sticky.
            rem <= done ? rem_sub : {rem_sub[24:0], 1'b0};
        end
    end

endmodule

// File: rtl/fp32_divider_seq.sv
// Sequential binary32 divider: handshake, special cases, exponent,
// round-to-nearest-even and packing around the restoring mantissa core.
module fp32_divider_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic        div_by_zero
);

    localparam logic signed [9:0] EXP_MAX_S = 10'(FP32_EXP_MAX);

    state_t state, state_next;

    logic [31:0]       a_r, b_r;
    logic              sign_r;
    logic signed [9:0] exp_r;
    logic              spec_r, spec_dz_r;
    logic [31:0]       spec_q_r;

    fp_class_t         ca, cb;
    logic              sign, spec, spec_dz;
    logic [31:0]       spec_q;
    logic signed [9:0] e_pre;

    logic              core_start, core_busy, core_done, core_rem_nz;
    logic [25:0]       core_q;

    logic signed [9:0] e_norm, e_fin;
    logic [22:0]       m_norm, m_fin;
    logic              g, s, inc;
    logic [23:0]       m_inc;
    logic [31:0]       round_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign e_pre = $signed({2'b00, a_r[30:23]} - {2'b00, b_r[30:23]} + 10'(FP32_BIAS));

    // Special-case resolution of the latched operands, highest priority first.
    always_comb begin
        ca      = classify(a_r);
        cb      = classify(b_r);
        sign    = a_r[31] ^ b_r[31];
        spec    = 1'b1;
        spec_dz = 1'b0;
        spec_q  = {sign, 31'h0};
        if (ca.nan || cb.nan)
            spec_q = FP32_QNAN;
        else if ((ca.zero && cb.zero) || (ca.inf && cb.inf))
            spec_q = FP32_QNAN;
        else if (ca.inf)
            spec_q = {sign, FP32_INF_MAG};
        else if (cb.inf)
            spec_q = {sign, 31'h0};
        else if (cb.zero) begin
            spec_q  = {sign, FP32_INF_MAG};
            spec_dz = 1'b1;
        end else if (ca.zero)
            spec_q = {sign, 31'h0};
        else
            spec = 1'b0;
    end

    assign core_start = (state == PREP) && !spec && !core_busy;

    mant_div_iter u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .ma     ({1'b1, a_r[22:0]}),
        .mb     ({1'b1, b_r[22:0]}),
        .busy   (core_busy),
        .done   (core_done),
        .q      (core_q),
        .rem_nz (core_rem_nz)
    );

    // Normalise the 26-bit quotient, round to nearest even, range-check.
    always_comb begin
        if (core_q[25]) begin
            m_norm = core_q[24:2];
            g      = core_q[1];
            s      = core_q[0] | core_rem_nz;
            e_norm = exp_r;
        end else begin
            m_norm = core_q[23:1];
            g      = core_q[0];
            s      = core_rem_nz;
            e_norm = exp_r - 10'sd1;
        end
        inc   = g & (s | m_norm[0]);
        m_inc = {1'b0, m_norm} + {23'h0, inc};
        if (m_inc[23]) begin
            m_fin = '0;
            e_fin = e_norm + 10'sd1;
        end else begin
            m_fin = m_inc[22:0];
            e_fin = e_norm;
        end
        if (e_fin >= EXP_MAX_S)
            round_q = {sign_r, FP32_INF_MAG};
        else if (e_fin <= 10'sd0)
            round_q = {sign_r, 31'h0};
        else
            round_q = {sign_r, e_fin[7:0], m_fin};
    end

    // Next state. Special cases also pass through the ROUND slot, which is
    // where the result register is written, so they land two edges after
    // accept while normal divisions land at 1 + 26 + 1.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = PREP;
            PREP:    state_next = spec ? ROUND : DIV;
            DIV:     if (core_done) state_next = ROUND;
            ROUND:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Operand capture, per-operation context and the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            spec_r      <= 1'b0;
            spec_q_r    <= '0;
            spec_dz_r   <= 1'b0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                a_r <= dividend;
                b_r <= divisor;
            end
            if (state == PREP) begin
                sign_r    <= sign;
                exp_r     <= e_pre;
                spec_r    <= spec;
                spec_q_r  <= spec_q;
                spec_dz_r <= spec_dz;
            end
            if (state == ROUND) begin
                quotient    <= spec_r ? spec_q_r : round_q;
                div_by_zero <= spec_r & spec_dz_r;
            end
        end
    end

endmodule
